noc_switch_allocator: RTL and testbench
=======================================

// Module: noc_switch_allocator
// PURPOSE
//  Switch allocator for the 5-port XY mesh router (N=0,S=1,E=2,W=3,L=4).
//  - Computes the XY route of each input's head flit.
//  - Arbitrates per output port, round-robin, and locks the output to the winner until its tail flit.
//  - Drives crossbar selects and per-input grants. Sits between the input buffers and the crossbar.
// PARAMETERS
//  XCOORD   2  X coordinate of this router
//  YCOORD   2  Y coordinate of this router
//  COORD_W  4  width of one destination coordinate field
// PORTS
//  clk         in   1          router clock; all logic on posedge
//  reset_n     in   1          asynchronous active-low reset
//  req_valid   in   5          input i holds a flit at its buffer head
//  req_head    in   5          flit at input i is a head flit
//  req_tail    in   5          flit at input i is a tail flit (head+tail = single-flit packet)
//  req_dest_x  in   5*COORD_W  destination X per input, slice i = [i*COORD_W +: COORD_W]
//  req_dest_y  in   5*COORD_W  destination Y per input; X and Y valid on head flits only
//  out_ready   in   5          downstream of output o accepts a flit this cycle
//  in_grant    out  5          input i's flit transfers this cycle (pop)
//  out_valid   out  5          output o carries a flit this cycle
//  out_sel     out  15         crossbar select per output, slice o = [3*o +: 3], value = input index
//  out_busy    out  5          output o is locked to an owner
//  proto_err   out  1          sticky: protocol violation detected
// BEHAVIOUR
//  Route (combinational, unsigned compare):
//  - dest_x > XCOORD -> E; dest_x < XCOORD -> W.
//  - Else dest_y > YCOORD -> N; dest_y < YCOORD -> S.
//  - Else L. U-turns are permitted.
//  Per-output FSM, states IDLE and BUSY; regs owner[2:0], rr_ptr[2:0].
//  - IDLE: candidates = inputs with req_valid & req_head, route == o, not already owning any output.
//  - IDLE pick: first candidate searching rr_ptr, rr_ptr+1, ... mod 5.
//  - IDLE with a winner: owner <= winner, -> BUSY. No flit moves in the allocation cycle (1-cycle alloc latency).
//  - BUSY: out_sel[o] = owner; out_valid[o] = in_grant[owner] = req_valid[owner] & out_ready[o] (combinational).
//  - BUSY, transfer with req_tail[owner]=1: -> IDLE next cycle; rr_ptr <= (owner+1) mod 5.
//  - BUSY, out_ready[o]=0: no grant; lock and owner held indefinitely.
//  Input-side rules:
//  - An input owns at most one output, so at most one grant per input.
//  - A head flit from an input that already owns an output is not a candidate until that packet's tail.
//  - A new packet from the same input re-arbitrates; it does not inherit the lock.
//  Boundary conditions:
//  - Several outputs may allocate in the same cycle to distinct inputs.
//  - An output freed in cycle t may re-allocate in cycle t+1 at the earliest.
//  - req_valid & ~req_head on an input that owns no output, or not in the allocation cycle -> proto_err <= 1, flit never granted.
//  - proto_err clears only on reset.
//  - Single-flit packet: alloc cycle, then 1 grant cycle, then IDLE.
//  Reset (async assert, sync release), in any state including mid-packet:
//  - All FSMs IDLE; owner=0; rr_ptr=0; proto_err=0; locks dropped.
//  - in_grant=0, out_valid=0, out_sel=0, out_busy=0.
// CONFIGURATION
//  NOC_ALLOC_STATS_EN defined:
//  - Adds output pkt_count [5*16-1:0], one 16-bit counter per output.
//  - Counter o increments on each tail transfer through output o; wraps 0xFFFF -> 0; reset 0.
//  NOC_ALLOC_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING
//  1 Reset asserted mid-packet (E locked to W) -> next edge: out_busy=0, in_grant=0, out_sel=0, proto_err=0.
//  2 W input head dest(3,2), then body, then tail, out_ready=all 1s:
//    - cycle 1: alloc.
//    - cycles 2-4: out_busy[2]=1, out_sel[8:6]=3, in_grant=5'b01000.
//    - cycle 5: out_busy[2]=0.
//  3 N and S heads dest(2,2) in the same cycle, 3-flit packets:
//    - N granted first (rr_ptr=0), 3 grants.
//    - S allocates the cycle after N's tail; afterwards rr_ptr[L]=2.
//  4 Local locked to E, out_ready[4]=0 for 4 cycles -> in_grant=0, out_valid[4]=0, out_busy[4]=1 held; resumes when ready=1.
//  5 Single-flit head+tail on L dest(1,2) -> W: alloc, one grant, IDLE; with NOC_ALLOC_STATS_EN, pkt_count[W]=1.
//  6 Body flit on idle E input, no head -> proto_err=1 stays 1; in_grant[2]=0 throughout.

Source files
------------

// File: rtl/noc_switch_allocator.sv
// Switch allocator for a 5-port XY mesh router: XY route, per-output round-robin lock, crossbar selects.
// Optional per-output tail-packet counters (pkt_count) are built when NOC_ALLOC_STATS_EN is defined.
module noc_switch_allocator #(
    parameter int XCOORD  = 2,
    parameter int YCOORD  = 2,
    parameter int COORD_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           req_valid,
    input  logic [4:0]           req_head,
    input  logic [4:0]           req_tail,
    input  logic [5*COORD_W-1:0] req_dest_x,
    input  logic [5*COORD_W-1:0] req_dest_y,
    input  logic [4:0]           out_ready,
    output logic [4:0]           in_grant,
    output logic [4:0]           out_valid,
    output logic [14:0]          out_sel,
    output logic [4:0]           out_busy,
`ifdef NOC_ALLOC_STATS_EN
    output logic [5*16-1:0]      pkt_count,
`endif
    output logic                 proto_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_S = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    localparam logic [COORD_W-1:0] X_POS = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] Y_POS = COORD_W'(YCOORD);

    state_t     state_q [5];
    state_t     state_d [5];
    logic [2:0] owner_q [5];
    logic [2:0] owner_d [5];
    logic [2:0] rr_q    [5];
    logic [2:0] rr_d    [5];
    logic [2:0] route   [5];
    logic [4:0] cand    [5];
    logic [4:0] owns;
    logic [4:0] tail_xfer;

    // First set bit of cand, scanning from ptr upward and wrapping modulo 5.
    function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
        logic [3:0] idx;
        logic       found;
        rr_pick = 3'd0;
        found   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'd5)
                idx = idx - 4'd5;
            if (!found && req[idx[2:0]]) begin
                found   = 1'b1;
                rr_pick = idx[2:0];
            end
        end
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            if (req_dest_x[i*COORD_W +: COORD_W] > X_POS)
                route[i] = PORT_E;
            else if (req_dest_x[i*COORD_W +: COORD_W] < X_POS)
                route[i] = PORT_W;
            else if (req_dest_y[i*COORD_W +: COORD_W] > Y_POS)
                route[i] = PORT_N;
            else if (req_dest_y[i*COORD_W +: COORD_W] < Y_POS)
                route[i] = PORT_S;
            else
                route[i] = PORT_L;
        end
    end

    // An input that already holds a lock may not compete for another output.
    always_comb begin
        owns = '0;
        for (int o = 0; o < 5; o++) begin
            if (state_q[o] == BUSY)
                owns[owner_q[o]] = 1'b1;
        end
        for (int o = 0; o < 5; o++) begin
            cand[o] = '0;
            for (int i = 0; i < 5; i++)
                cand[o][i] = req_valid[i] & req_head[i] & ~owns[i] & (route[i] == 3'(o));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= 3'd0;
                rr_q[o]    <= 3'd0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
            end
        end
    end

    always_comb begin
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (|cand[o]) begin
                        owner_d[o] = rr_pick(cand[o], rr_q[o]);
                        state_d[o] = BUSY;
                    end
                end
                BUSY: begin
                    if (tail_xfer[o]) begin
                        state_d[o] = IDLE;
                        rr_d[o]    = (owner_q[o] == 3'd4) ? 3'd0 : owner_q[o] + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_grant  = '0;
        out_valid = '0;
        out_sel   = '0;
        out_busy  = '0;
        tail_xfer = '0;
        for (int o = 0; o < 5; o++) begin
            if (state_q[o] == BUSY) begin
                out_busy[o]      = 1'b1;
                out_sel[3*o +: 3] = owner_q[o];
                if (req_valid[owner_q[o]] && out_ready[o]) begin
                    out_valid[o]          = 1'b1;
                    in_grant[owner_q[o]]  = 1'b1;
                    tail_xfer[o]          = req_tail[owner_q[o]];
                end
            end
        end
    end

    // Any non-head flit at an input without a lock is a framing error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            proto_err <= 1'b0;
        else if (|(req_valid & ~req_head & ~owns))
            proto_err <= 1'b1;
    end

`ifdef NOC_ALLOC_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (tail_xfer[o])
                    pkt_count[o*16 +: 16] <= pkt_count[o*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Scoreboard bench for noc_switch_allocator: directed cycles push expectations, a negedge monitor checks them.
module tb_noc_switch_allocator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  req_valid, req_head, req_tail, out_ready;
    logic [19:0] req_dest_x, req_dest_y;
    logic [4:0]  in_grant, out_valid, out_busy;
    logic [14:0] out_sel;
    logic        proto_err;
`ifdef NOC_ALLOC_STATS_EN
    logic [79:0] pkt_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [4:0]  g;
        logic [4:0]  v;
        logic [14:0] s;
        logic [4:0]  b;
        logic        p;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    noc_switch_allocator dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_head(req_head),
        .req_tail(req_tail),
        .req_dest_x(req_dest_x),
        .req_dest_y(req_dest_y),
        .out_ready(out_ready),
        .in_grant(in_grant),
        .out_valid(out_valid),
        .out_sel(out_sel),
        .out_busy(out_busy),
`ifdef NOC_ALLOC_STATS_EN
        .pkt_count(pkt_count),
`endif
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] at(input int i, input logic [3:0] val);
        return 20'(val) << (4 * i);
    endfunction

    task automatic checkOutput(input string nm, input logic [14:0] act, input logic [14:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // One cycle of stimulus driven just after the edge, with its expected outputs queued.
    task automatic applyStimulus(input logic rst_v, input logic [4:0] v, input logic [4:0] h,
                                 input logic [4:0] t, input logic [19:0] dx, input logic [19:0] dy,
                                 input logic [4:0] rdy, input logic [4:0] eg, input logic [4:0] ev,
                                 input logic [14:0] es, input logic [4:0] eb, input logic ep,
                                 input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n    = rst_v;
        req_valid  = v;
        req_head   = h;
        req_tail   = t;
        req_dest_x = dx;
        req_dest_y = dy;
        out_ready  = rdy;
        e.g = eg; e.v = ev; e.s = es; e.b = eb; e.p = ep; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic idleCycle(input logic ep, input string nm);
        applyStimulus(1'b1, 5'b0, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111,
                      5'b0, 5'b0, 15'h0, 5'b0, ep, nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.nm, ".in_grant"},  15'(in_grant),  15'(e.g));
            checkOutput({e.nm, ".out_valid"}, 15'(out_valid), 15'(e.v));
            checkOutput({e.nm, ".out_sel"},   out_sel,        e.s);
            checkOutput({e.nm, ".out_busy"},  15'(out_busy),  15'(e.b));
            checkOutput({e.nm, ".proto_err"}, 15'(proto_err), 15'(e.p));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [19:0] dx, dy;
        reset_n = 1'b0;
        req_valid = '0; req_head = '0; req_tail = '0;
        req_dest_x = '0; req_dest_y = '0; out_ready = 5'b11111;

        applyStimulus(1'b0, 5'b0, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "rst0");
        idleCycle(1'b0, "rst_release");

        // Reset while W holds E mid-packet
        dx = at(3, 4'd3); dy = at(3, 4'd2);
        applyStimulus(1'b1, 5'b01000, 5'b01000, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t1_alloc");
        applyStimulus(1'b1, 5'b01000, 5'b0, 5'b0, dx, dy, 5'b11111, 5'b01000, 5'b00100, 15'h00C0, 5'b00100, 1'b0, "t1_body");
        applyStimulus(1'b0, 5'b01000, 5'b0, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t1_rst");
        applyStimulus(1'b0, 5'b0, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t1_rst2");
        idleCycle(1'b0, "t1_after");

        // W input 3-flit packet to E
        applyStimulus(1'b1, 5'b01000, 5'b01000, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t2_alloc");
        applyStimulus(1'b1, 5'b01000, 5'b01000, 5'b0, dx, dy, 5'b11111, 5'b01000, 5'b00100, 15'h00C0, 5'b00100, 1'b0, "t2_head");
        applyStimulus(1'b1, 5'b01000, 5'b0, 5'b0, dx, dy, 5'b11111, 5'b01000, 5'b00100, 15'h00C0, 5'b00100, 1'b0, "t2_body");
        applyStimulus(1'b1, 5'b01000, 5'b0, 5'b01000, dx, dy, 5'b11111, 5'b01000, 5'b00100, 15'h00C0, 5'b00100, 1'b0, "t2_tail");
        idleCycle(1'b0, "t2_free");

        // N and S contend for L
        dx = at(0, 4'd2) | at(1, 4'd2); dy = dx;
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t3_alloc");
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b0, dx, dy, 5'b11111, 5'b00001, 5'b10000, 15'h0, 5'b10000, 1'b0, "t3_n_head");
        applyStimulus(1'b1, 5'b00011, 5'b00010, 5'b0, dx, dy, 5'b11111, 5'b00001, 5'b10000, 15'h0, 5'b10000, 1'b0, "t3_n_body");
        applyStimulus(1'b1, 5'b00011, 5'b00010, 5'b00001, dx, dy, 5'b11111, 5'b00001, 5'b10000, 15'h0, 5'b10000, 1'b0, "t3_n_tail");
        applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t3_s_alloc");
        applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b0, dx, dy, 5'b11111, 5'b00010, 5'b10000, 15'h1000, 5'b10000, 1'b0, "t3_s_head");
        applyStimulus(1'b1, 5'b00010, 5'b0, 5'b0, dx, dy, 5'b11111, 5'b00010, 5'b10000, 15'h1000, 5'b10000, 1'b0, "t3_s_body");
        applyStimulus(1'b1, 5'b00010, 5'b0, 5'b00010, dx, dy, 5'b11111, 5'b00010, 5'b10000, 15'h1000, 5'b10000, 1'b0, "t3_s_tail");
        idleCycle(1'b0, "t3_free");
        // rr_ptr[L]=2 now: N (index 0) beats S (index 1) again
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b00011, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t3_rr_alloc");
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b00011, dx, dy, 5'b11111, 5'b00001, 5'b10000, 15'h0, 5'b10000, 1'b0, "t3_rr_n");
        applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t3_rr_s_alloc");
        applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, dx, dy, 5'b11111, 5'b00010, 5'b10000, 15'h1000, 5'b10000, 1'b0, "t3_rr_s");
        idleCycle(1'b0, "t3_rr_free");

        // E input locked to L, L output stalled for 4 cycles
        dx = at(2, 4'd2); dy = at(2, 4'd2);
        applyStimulus(1'b1, 5'b00100, 5'b00100, 5'b0, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t4_alloc");
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 5'b00100, 5'b00100, 5'b0, dx, dy, 5'b01111, 5'b0, 5'b0, 15'h2000, 5'b10000, 1'b0, "t4_stall");
        applyStimulus(1'b1, 5'b00100, 5'b00100, 5'b0, dx, dy, 5'b11111, 5'b00100, 5'b10000, 15'h2000, 5'b10000, 1'b0, "t4_resume");
        applyStimulus(1'b1, 5'b00100, 5'b0, 5'b00100, dx, dy, 5'b11111, 5'b00100, 5'b10000, 15'h2000, 5'b10000, 1'b0, "t4_tail");
        idleCycle(1'b0, "t4_free");

        // Single-flit packet L -> W
        dx = at(4, 4'd1); dy = at(4, 4'd2);
        applyStimulus(1'b1, 5'b10000, 5'b10000, 5'b10000, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t5_alloc");
        applyStimulus(1'b1, 5'b10000, 5'b10000, 5'b10000, dx, dy, 5'b11111, 5'b10000, 5'b01000, 15'h0800, 5'b01000, 1'b0, "t5_grant");
        idleCycle(1'b0, "t5_free");

        // Two outputs allocate in the same cycle: N -> E, S -> W
        dx = at(0, 4'd3) | at(1, 4'd1); dy = at(0, 4'd2) | at(1, 4'd2);
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b00011, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "par_alloc");
        applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b00011, dx, dy, 5'b11111, 5'b00011, 5'b01100, 15'h0200, 5'b01100, 1'b0, "par_grant");
        idleCycle(1'b0, "par_free");

        // Body flit on an idle E input
        applyStimulus(1'b1, 5'b00100, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t6_body");
        applyStimulus(1'b1, 5'b00100, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b1, "t6_err");
        idleCycle(1'b1, "t6_sticky1");
        idleCycle(1'b1, "t6_sticky2");
        applyStimulus(1'b0, 5'b0, 5'b0, 5'b0, 20'h0, 20'h0, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "t6_rst_clear");

        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

`ifdef NOC_ALLOC_STATS_EN
        // Counters were cleared by the final reset; repeat one single-flit L -> W packet and one to E
        dx = at(4, 4'd1) | at(3, 4'd3); dy = at(4, 4'd2) | at(3, 4'd2);
        applyStimulus(1'b1, 5'b11000, 5'b11000, 5'b11000, dx, dy, 5'b11111, 5'b0, 5'b0, 15'h0, 5'b0, 1'b0, "st_alloc");
        applyStimulus(1'b1, 5'b11000, 5'b11000, 5'b11000, dx, dy, 5'b11111, 5'b11000, 5'b01100, 15'h08C0, 5'b01100, 1'b0, "st_grant");
        idleCycle(1'b0, "st_free");
        repeat (2) @(negedge clk);
        checkOutput("pkt_count_w", 15'(pkt_count[3*16 +: 16]), 15'd1);
        checkOutput("pkt_count_e", 15'(pkt_count[2*16 +: 16]), 15'd1);
        checkOutput("pkt_count_l", 15'(pkt_count[4*16 +: 16]), 15'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
